// File: rtl/wdata_handler.sv
// -----------------------------------------------------------------------------
// wdata_handler
//
// Write-back path for one result tile of the systolic array.
// - A start pulse captures the tile base address.
// - Result rows from the array are buffered in a small FIFO.
// - Each buffered row is written to memory at consecutive row-stride
//   addresses, using a request/grant handshake.
// - A one-cycle done pulse follows the last granted write.
//
// Ports
//   clk_i, rst_ni        clock (rising edge), asynchronous active-low reset
//   start_i, addr_c_i    begin a tile write-back at base address addr_c_i
//   busy_o, done_o       busy while not idle; done pulses once per tile
//   row_valid_i, row_i   result row offered by the array
//   row_ready_o          handler accepts the offered row this cycle
//   en_c_o               memory write request
//   addr_c_o, wdata_c_o  write address and write data of that request
//   gnt_c_i              memory accepts the request this cycle
// -----------------------------------------------------------------------------
module wdata_handler #(
    parameter int SYS_ARRAY_SIZE = 4,
    parameter int ROW_BITS       = 32,
    parameter int ROW_BYTES      = 16,
    parameter int ADDR_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] addr_c_i,
    output logic                  busy_o,
    output logic                  done_o,
    input  logic                  row_valid_i,
    input  logic [ROW_BITS-1:0]   row_i,
    output logic                  row_ready_o,
    output logic                  en_c_o,
    output logic [ADDR_WIDTH-1:0] addr_c_o,
    output logic [ROW_BITS-1:0]   wdata_c_o,
    input  logic                  gnt_c_i
);

    localparam int CW = $clog2(SYS_ARRAY_SIZE + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CW-1:0]         acc_cnt_q, acc_cnt_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [OW-1:0]         occ_q, occ_d;
    logic [ROW_BITS-1:0]   mem_q [FIFO_DEPTH];

    logic push;
    logic pop;

    // Ready depends only on registered state, so a push can never land on a
    // full FIFO even when a pop happens in the same cycle.
    assign row_ready_o = (state_q == S_WRITE)
                       && (occ_q != OW'(FIFO_DEPTH))
                       && (acc_cnt_q < CW'(SYS_ARRAY_SIZE));
    assign en_c_o      = (state_q == S_WRITE) && (occ_q != '0);
    assign addr_c_o    = addr_q;
    assign wdata_c_o   = en_c_o ? mem_q[rptr_q] : '0;
    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);

    assign push = row_valid_i && row_ready_o;
    assign pop  = en_c_o && gnt_c_i;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        occ_d     = occ_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d   = S_WRITE;
                    addr_d    = addr_c_i;
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                    wptr_d    = '0;
                    rptr_d    = '0;
                    occ_d     = '0;
                end
            end
            S_WRITE: begin
                if (push) begin
                    wptr_d    = wptr_q + PW'(1);
                    acc_cnt_d = acc_cnt_q + CW'(1);
                end
                if (pop) begin
                    rptr_d   = rptr_q + PW'(1);
                    // Address wraps naturally at ADDR_WIDTH bits.
                    addr_d   = addr_q + ADDR_WIDTH'(ROW_BYTES);
                    wr_cnt_d = wr_cnt_q + CW'(1);
                    if (wr_cnt_q == CW'(SYS_ARRAY_SIZE - 1)) begin
                        state_d = S_DONE;
                    end
                end
                case ({push, pop})
                    2'b10:   occ_d = occ_q + OW'(1);
                    2'b01:   occ_d = occ_q - OW'(1);
                    default: occ_d = occ_q;
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            occ_q     <= occ_d;
        end
    end

    // Row storage is pure data: it is not reset.
    // Emptiness is tracked by occ_q, and wdata_c_o is masked while en_c_o is low.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= row_i;
        end
    end

endmodule
